// File: rtl/axi_stream_if.sv
// Shared AXI-stream channel types for the cubic pipeline.
// Master-to-slave bundle: tvalid, tdata (64-bit IEEE-754 double bits), tlast.
// Slave-to-master bundle: tready.
package axi_stream_if;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic        tlast;
    } axi_stream_mastero_slavei_t;

    typedef struct packed {
        logic tready;
    } axi_stream_masteri_slaveo_t;

endpackage

// File: rtl/axi_stream_pkg.sv
// Package for the stream sink. It holds the stream widths and re-exports the
// channel typedefs from axi_stream_if under the same names, so users import a
// single package.
package axi_stream_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned PHASE_W     = 4;

    typedef axi_stream_if::axi_stream_mastero_slavei_t axi_stream_mastero_slavei_t;
    typedef axi_stream_if::axi_stream_masteri_slaveo_t axi_stream_masteri_slaveo_t;

endpackage

// File: rtl/stream_sink_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk     - clock, all state on the rising edge
//   clr_i   - synchronous clear of pointers and count (storage is not cleared)
//   push_i  - write wdata_i; ignored when full
//   wdata_i - entry to write
//   pop_i   - drop the head entry; ignored when empty
//   full_o  - DEPTH entries held
//   empty_o - no entries held
//   count_o - entries held
//   head_o  - head entry, 0 when empty
module stream_sink_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 65,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_stream_result_sink.sv
// Slave-side terminator for the 64-bit result stream. Buffers {TLAST, TDATA}
// in a FWFT FIFO drained through a simple read port, counts frames, applies a
// phase-driven backpressure pattern and flags sticky master protocol errors.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   previ       - TVALID/TDATA/TLAST from the upstream master
//   prevo       - TREADY to the upstream master
//   rd_en       - pop the head entry (ignored when empty)
//   rd_valid    - FIFO non-empty
//   rd_data     - head TDATA, 0 when empty
//   rd_last     - head TLAST, 0 when empty
//   count       - entries held
//   frames      - accepted beats with TLAST, wrapping
//   err_drop    - sticky: TVALID withdrawn while stalled
//   err_change  - sticky: TDATA/TLAST changed while stalled
module axi_stream_result_sink
    import axi_stream_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter logic [15:0] STALL_MASK = 16'h0000,
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  axi_stream_mastero_slavei_t previ,
    output axi_stream_masteri_slaveo_t prevo,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [AXIS_DATA_W-1:0]     rd_data,
    output logic                       rd_last,
    output logic [CW-1:0]              count,
    output logic [15:0]                frames,
    output logic                       err_drop,
    output logic                       err_change
);

    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [15:0]            frames_q, frames_d;
    logic                   stalled_q, stalled_d;
    logic [AXIS_DATA_W-1:0] stall_data_q;
    logic                   stall_last_q;
    logic                   err_drop_q, err_drop_d;
    logic                   err_change_q, err_change_d;

    logic                   fifo_full, fifo_empty;
    logic [AXIS_DATA_W:0]   fifo_head;
    logic                   tready;
    logic                   accept;

    // Registers only: never looks at TVALID.
    assign tready = !fifo_full && !STALL_MASK[phase_q];
    assign accept = previ.tvalid && tready;

    always_comb begin
        prevo        = '0;
        prevo.tready = tready;
    end

    stream_sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AXIS_DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .clr_i   (rst),
        .push_i  (accept),
        .wdata_i ({previ.tlast, previ.tdata}),
        .pop_i   (rd_en),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count),
        .head_o  (fifo_head)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_head[AXIS_DATA_W-1:0];
    assign rd_last  = fifo_head[AXIS_DATA_W];

    always_comb begin
        phase_d      = phase_q + PHASE_W'(1);
        frames_d     = frames_q;
        stalled_d    = previ.tvalid && !tready;
        err_drop_d   = err_drop_q;
        err_change_d = err_change_q;
        if (accept && previ.tlast) begin
            frames_d = frames_q + 16'd1;
        end
        // A stalled beat must be held unchanged until its handshake.
        if (stalled_q && !previ.tvalid) begin
            err_drop_d = 1'b1;
        end
        if (stalled_q && previ.tvalid &&
            ((previ.tdata != stall_data_q) || (previ.tlast != stall_last_q))) begin
            err_change_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            frames_q     <= '0;
            stalled_q    <= 1'b0;
            stall_data_q <= '0;
            stall_last_q <= 1'b0;
            err_drop_q   <= 1'b0;
            err_change_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            frames_q     <= frames_d;
            stalled_q    <= stalled_d;
            stall_data_q <= previ.tdata;
            stall_last_q <= previ.tlast;
            err_drop_q   <= err_drop_d;
            err_change_q <= err_change_d;
        end
    end

    assign frames     = frames_q;
    assign err_drop   = err_drop_q;
    assign err_change = err_change_q;

endmodule

// File: tb/tb_axi_stream_result_sink.sv
// Directed bench for axi_stream_result_sink. Instance A uses the default
// (no stall) mask, instance B uses STALL_MASK=16'h0005. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_axi_stream_result_sink;
    import axi_stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A
    logic                       rst_a;
    axi_stream_mastero_slavei_t prev_a;
    axi_stream_masteri_slaveo_t prevo_a;
    logic                       rd_en_a, rd_valid_a, rd_last_a;
    logic [63:0]                rd_data_a;
    logic [3:0]                 count_a;
    logic [15:0]                frames_a;
    logic                       err_drop_a, err_change_a;

    // Instance B
    logic                       rst_b;
    axi_stream_mastero_slavei_t prev_b;
    axi_stream_masteri_slaveo_t prevo_b;
    logic                       rd_en_b, rd_valid_b, rd_last_b;
    logic [63:0]                rd_data_b;
    logic [3:0]                 count_b;
    logic [15:0]                frames_b;
    logic                       err_drop_b, err_change_b;

    axi_stream_result_sink #(
        .DEPTH      (8),
        .STALL_MASK (16'h0000)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .previ      (prev_a),
        .prevo      (prevo_a),
        .rd_en      (rd_en_a),
        .rd_valid   (rd_valid_a),
        .rd_data    (rd_data_a),
        .rd_last    (rd_last_a),
        .count      (count_a),
        .frames     (frames_a),
        .err_drop   (err_drop_a),
        .err_change (err_change_a)
    );

    axi_stream_result_sink #(
        .DEPTH      (8),
        .STALL_MASK (16'h0005)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .previ      (prev_b),
        .prevo      (prevo_b),
        .rd_en      (rd_en_b),
        .rd_valid   (rd_valid_b),
        .rd_data    (rd_data_b),
        .rd_last    (rd_last_b),
        .count      (count_b),
        .frames     (frames_b),
        .err_drop   (err_drop_b),
        .err_change (err_change_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: through the rising edge, back to the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_tready"}, 64'(prevo_a.tready), 64'd1);
        check({tag, "_rd_valid"}, 64'(rd_valid_a), 64'd0);
        check({tag, "_rd_data"}, rd_data_a, 64'd0);
        check({tag, "_rd_last"}, 64'(rd_last_a), 64'd0);
        check({tag, "_count"}, 64'(count_a), 64'd0);
        check({tag, "_frames"}, 64'(frames_a), 64'd0);
        check({tag, "_err_drop"}, 64'(err_drop_a), 64'd0);
        check({tag, "_err_change"}, 64'(err_change_a), 64'd0);
    endtask

    task automatic push_a(input logic [63:0] data, input logic last);
        prev_a.tvalid = 1'b1;
        prev_a.tdata  = data;
        prev_a.tlast  = last;
        cyc();
        prev_a.tvalid = 1'b0;
        prev_a.tlast  = 1'b0;
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int k;
        int popk;
        int phase_m;
        logic exp_rdy;

        rst_a   = 1'b1;
        rst_b   = 1'b1;
        prev_a  = '0;
        prev_b  = '0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        @(negedge clk);
        cyc();
        rst_a = 1'b0;
        check_reset_a("rst");

        // Single beat with TLAST, 1 cycle latency.
        prev_a.tvalid = 1'b1;
        prev_a.tdata  = 64'h3FF8000000000000;
        prev_a.tlast  = 1'b1;
        check("t1_tready", 64'(prevo_a.tready), 64'd1);
        cyc();
        prev_a.tvalid = 1'b0;
        prev_a.tlast  = 1'b0;
        check("t1_rd_valid", 64'(rd_valid_a), 64'd1);
        check("t1_rd_data", rd_data_a, 64'h3FF8000000000000);
        check("t1_rd_last", 64'(rd_last_a), 64'd1);
        check("t1_frames", 64'(frames_a), 64'd1);
        check("t1_count", 64'(count_a), 64'd1);
        rd_en_a = 1'b1;
        cyc();
        rd_en_a = 1'b0;
        check("t1_pop_count", 64'(count_a), 64'd0);
        check("t1_pop_valid", 64'(rd_valid_a), 64'd0);
        check("t1_empty_data", rd_data_a, 64'd0);

        // Offer 10 beats back to back into an empty DEPTH=8 FIFO.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            prev_a.tvalid = 1'b1;
            prev_a.tdata  = 64'h100 + 64'(acc);
            prev_a.tlast  = 1'b0;
            if (i >= 8) check("t2_tready_low", 64'(prevo_a.tready), 64'd0);
            if (prevo_a.tready) acc++;
            cyc();
        end
        check("t2_accepted", 64'(acc), 64'd8);
        check("t2_count_full", 64'(count_a), 64'd8);
        rd_en_a = 1'b1;
        check("t2_full_no_pass", 64'(prevo_a.tready), 64'd0);
        cyc();
        rd_en_a = 1'b0;
        check("t2_tready_after_pop", 64'(prevo_a.tready), 64'd1);
        check("t2_count_after_pop", 64'(count_a), 64'd7);
        check("t2_head_after_pop", rd_data_a, 64'h101);
        cyc();
        prev_a.tvalid = 1'b0;
        check("t2_ninth_accepted", 64'(count_a), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            rd_en_a = 1'b1;
            check("t2_drain", rd_data_a, 64'h100 + 64'(i));
            cyc();
        end
        rd_en_a = 1'b0;
        check("t2_drained", 64'(count_a), 64'd0);
        check("t2_err_drop", 64'(err_drop_a), 64'd0);
        check("t2_err_change", 64'(err_change_a), 64'd0);

        // Simultaneous push and pop with count=3.
        for (int i = 0; i < 3; i++) push_a(64'h300 + 64'(i), 1'b0);
        check("t3_count3", 64'(count_a), 64'd3);
        prev_a.tvalid = 1'b1;
        prev_a.tdata  = 64'h303;
        rd_en_a       = 1'b1;
        check("t3_head_before", rd_data_a, 64'h300);
        cyc();
        prev_a.tvalid = 1'b0;
        rd_en_a       = 1'b0;
        check("t3_count_same", 64'(count_a), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            rd_en_a = 1'b1;
            check("t3_order", rd_data_a, 64'h300 + 64'(i));
            cyc();
        end
        rd_en_a = 1'b0;
        check("t3_empty", 64'(count_a), 64'd0);

        // Reset mid-operation with count=5, frames=2.
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) push_a(64'h500 + 64'(i), (i == 1) || (i == 4));
        check("t5_count5", 64'(count_a), 64'd5);
        check("t5_frames2", 64'(frames_a), 64'd2);
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        check_reset_a("t5");
        push_a(64'h5AA, 1'b0);
        check("t5_first_after_rst", rd_data_a, 64'h5AA);
        check("t5_count1", 64'(count_a), 64'd1);

        // Protocol violations while stalled by a full FIFO.
        for (int i = 0; i < 7; i++) push_a(64'h600 + 64'(i), 1'b0);
        check("t4_full", 64'(count_a), 64'd8);
        prev_a.tvalid = 1'b1;
        prev_a.tdata  = 64'h4000000000000000;
        check("t4_stalled", 64'(prevo_a.tready), 64'd0);
        cyc();
        check("t4_no_err_yet", 64'(err_change_a), 64'd0);
        prev_a.tdata = 64'h0;
        cyc();
        check("t4_err_change", 64'(err_change_a), 64'd1);
        check("t4_no_drop_yet", 64'(err_drop_a), 64'd0);
        prev_a.tvalid = 1'b0;
        cyc();
        check("t4_err_drop", 64'(err_drop_a), 64'd1);
        cyc();
        check("t4_drop_sticky", 64'(err_drop_a), 64'd1);
        check("t4_change_sticky", 64'(err_change_a), 64'd1);

        // Instance B: mask 16'h0005, continuous TVALID and continuous pops.
        cyc();
        rst_b = 1'b0;
        phase_m = 0;
        k       = 0;
        popk    = 0;
        rd_en_b = 1'b1;
        for (int c = 0; c < 80 && popk < 16; c++) begin
            if (k < 16) begin
                prev_b.tvalid = 1'b1;
                prev_b.tdata  = 64'h200 + 64'(k);
                prev_b.tlast  = (k == 15);
            end else begin
                prev_b.tvalid = 1'b0;
                prev_b.tlast  = 1'b0;
            end
            exp_rdy = !((phase_m == 0) || (phase_m == 2));
            check("b_tready", 64'(prevo_b.tready), 64'(exp_rdy));
            if (rd_valid_b) begin
                check("b_order", rd_data_b, 64'h200 + 64'(popk));
                popk++;
            end
            if (prev_b.tvalid && prevo_b.tready) k++;
            cyc();
            phase_m = (phase_m + 1) % 16;
        end
        rd_en_b       = 1'b0;
        prev_b.tvalid = 1'b0;
        check("b_all_popped", 64'(popk), 64'd16);
        check("b_frames", 64'(frames_b), 64'd1);
        check("b_err_drop", 64'(err_drop_b), 64'd0);
        check("b_err_change", 64'(err_change_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
